execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands, funct3 and destination register of M-extension instructions issued by the decode/execute pipeline register. The unit stalls the front of the pipeline while it iterates. It then presents a single-cycle result for the execute→memory boundary. The ALU path is untouched; this unit runs alongside it.

---
 rtl/execute_muldiv.sv | 150 +++++++++++++++
 tb/tb_execute_muldiv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, one step per cycle.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E_start,
  input  logic                  E_flush,
  input  logic [2:0]            E_funct3,
  input  logic [DATA_WIDTH-1:0] E_op_a,
  input  logic [DATA_WIDTH-1:0] E_op_b,
  input  logic [4:0]            E_rd,
  output logic                  E_md_stall,
  output logic                  E_md_done,
  output logic [DATA_WIDTH-1:0] E_md_result,
  output logic [4:0]            E_md_rd
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_pend_q, rd_q;
  logic [W-1:0]    mag_b_q;
  logic            neg_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    pend_q, res_q;
  logic            done_q;

  // Operand decode for a new instruction
  logic            sgn_a, sgn_b, a_neg, b_neg, neg_d, div_zero, div_ovf;
  logic [W-1:0]    mag_a_d, mag_b_d, fast_res;

  always_comb begin
    sgn_a    = (E_funct3 == 3'b001) || (E_funct3 == 3'b010) ||
               (E_funct3 == 3'b100) || (E_funct3 == 3'b110);
    sgn_b    = (E_funct3 == 3'b001) || (E_funct3 == 3'b100) || (E_funct3 == 3'b110);
    a_neg    = sgn_a && E_op_a[W-1];
    b_neg    = sgn_b && E_op_b[W-1];
    mag_a_d  = a_neg ? -E_op_a : E_op_a;
    mag_b_d  = b_neg ? -E_op_b : E_op_b;
    neg_d    = (E_funct3[2] && E_funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = E_funct3[2] && (E_op_b == '0);
    div_ovf  = ((E_funct3 == 3'b100) || (E_funct3 == 3'b110)) &&
               (E_op_a == {1'b1, {(W-1){1'b0}}}) && (E_op_b == '1);
    if (div_zero) fast_res = E_funct3[1] ? E_op_a : '1;
    else          fast_res = E_funct3[1] ? '0 : E_op_a;
  end

  // One iteration step and the result it would finalise to
  logic [W:0]      mul_sum, div_r;
  logic [W-1:0]    div_sub;
  logic            div_ge;
  logic [2*W-1:0]  step_acc, prod_s;
  logic [W-1:0]    quot, rem, fin_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_r    = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge   = div_r >= {1'b0, mag_b_q};
    div_sub  = div_r[W-1:0] - mag_b_q;
    if (!funct3_q[2])  step_acc = {mul_sum, acc_q[W-1:1]};
    else if (div_ge)   step_acc = {div_sub, acc_q[W-2:0], 1'b1};
    else               step_acc = {div_r[W-1:0], acc_q[W-2:0], 1'b0};
    prod_s   = neg_q ? -step_acc : step_acc;
    quot     = neg_q ? -step_acc[W-1:0] : step_acc[W-1:0];
    rem      = neg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
    case (funct3_q)
      3'b000:                 fin_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*W-1:W];
      3'b100, 3'b101:         fin_res = quot;
      default:                fin_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_pend_q <= '0;
      rd_q      <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      pend_q    <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (E_start && !E_flush) begin
            funct3_q  <= E_funct3;
            rd_pend_q <= E_rd;
            neg_q     <= neg_d;
            if (div_zero || div_ovf) begin
              pend_q  <= fast_res;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              // Divide shifts the dividend out of the low half; multiply shifts the multiplier
              mag_b_q <= E_funct3[2] ? mag_b_d : mag_a_d;
              acc_q   <= {{W{1'b0}}, (E_funct3[2] ? mag_a_d : mag_b_d)};
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (E_flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            acc_q <= step_acc;
            if (cnt_q == CW'(W-1)) begin
              cnt_q   <= '0;
              pend_q  <= fin_res;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (!E_flush) begin
            res_q <= pend_q;
            rd_q  <= rd_pend_q;
          end
        end
      endcase
    end
  end

  // A flush in DONE suppresses the pulse and leaves the visible result untouched
  logic show_pend;
  assign show_pend   = done_q && !E_flush;
  assign E_md_done   = show_pend;
  assign E_md_result = show_pend ? pend_q : res_q;
  assign E_md_rd     = show_pend ? rd_pend_q : rd_q;
  assign E_md_stall  = ((state_q == IDLE) && E_start && !E_flush) || (state_q == BUSY);

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: vector table plus flush/reset sequences.
module tb_execute_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        E_start, E_flush;
  logic [2:0]  E_funct3;
  logic [31:0] E_op_a, E_op_b;
  logic [4:0]  E_rd;
  logic        E_md_stall, E_md_done;
  logic [31:0] E_md_result;
  logic [4:0]  E_md_rd;

  int errors = 0;
  int checks = 0;

  execute_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .E_start(E_start), .E_flush(E_flush),
    .E_funct3(E_funct3), .E_op_a(E_op_a), .E_op_b(E_op_b), .E_rd(E_rd),
    .E_md_stall(E_md_stall), .E_md_done(E_md_done),
    .E_md_result(E_md_result), .E_md_rd(E_md_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input string nm);
    int got;
    int stall_bad;
    E_funct3 = f; E_op_a = a; E_op_b = b; E_rd = rd; E_start = 1'b1;
    #1;
    check({nm, " stall_start"}, {31'd0, E_md_stall}, 32'd1);
    tick();
    E_start = 1'b0;
    got = 0;
    stall_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (E_md_done) begin
        got = c;
        break;
      end
      if (!E_md_stall) stall_bad++;
      tick();
    end
    check({nm, " latency"}, got, lat);
    check({nm, " result"}, E_md_result, exp);
    check({nm, " rd"}, {27'd0, E_md_rd}, {27'd0, rd});
    check({nm, " stall_done"}, {31'd0, E_md_stall}, 32'd0);
    check({nm, " stall_busy_low"}, stall_bad, 32'd0);
    tick();
    check({nm, " done_single"}, {31'd0, E_md_done}, 32'd0);
    check({nm, " result_held"}, E_md_result, exp);
  endtask

  initial begin
    int dones;
    int stall_seen;
    int got;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, "MUL 7*-3"};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33, "MULHU max*max"};
    vecs[2]  = '{3'b001, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 33, "MULH min*min"};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33, "MULHSU -1*2"};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33, "DIV -7/2"};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33, "REM -7/2"};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       33, "DIVU 100/7"};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        33, "REMU 100/7"};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1,  "DIV 5/0"};
    vecs[9]  = '{3'b111, 32'd5,        32'd0,        5'd10, 32'd5,        1,  "REMU 5/0"};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1,  "DIV ovf"};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1,  "REM ovf"};
    vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'd1,        33, "MUL max*max"};
    vecs[13] = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd14, 32'h3FFFFFFF, 33, "MULH maxpos^2"};
    vecs[14] = '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 33, "DIV 7/-2"};
    vecs[15] = '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        33, "REM 7/-2"};
    vecs[16] = '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd17, 32'hFFFFFFFF, 33, "DIVU max/1"};
    vecs[17] = '{3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        1,  "REM 5/0"};

    rst = 1'b1; E_start = 1'b0; E_flush = 1'b0;
    E_funct3 = 3'b000; E_op_a = '0; E_op_b = '0; E_rd = '0;
    tick(); tick();
    check("reset done", {31'd0, E_md_done}, 32'd0);
    check("reset result", E_md_result, 32'd0);
    check("reset rd", {27'd0, E_md_rd}, 32'd0);
    check("reset stall", {31'd0, E_md_stall}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat, vecs[i].nm);

    // Flush mid-divide: no pulse, result kept, then a fresh multiply.
    E_funct3 = 3'b101; E_op_a = 32'd100; E_op_b = 32'd7; E_rd = 5'd20; E_start = 1'b1;
    tick();
    E_start = 1'b0;
    dones = 0;
    for (int c = 1; c < 10; c++) begin
      if (E_md_done) dones++;
      tick();
    end
    E_flush = 1'b1;
    tick();
    E_flush = 1'b0;
    #1;
    check("flush stall", {31'd0, E_md_stall}, 32'd0);
    check("flush done", {31'd0, E_md_done}, 32'd0);
    check("flush result kept", E_md_result, 32'd5);
    check("flush rd kept", {27'd0, E_md_rd}, 32'd18);
    for (int c = 0; c < 40; c++) begin
      if (E_md_done) dones++;
      if (c < 39) tick();
    end
    check("flush no pulse", dones, 32'd0);
    tick();
    run_op(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33, "MUL 3*4 after flush");

    // Start with flush in IDLE is refused; start held through DONE is ignored.
    E_funct3 = 3'b101; E_op_a = 32'd9; E_op_b = 32'd3; E_rd = 5'd22;
    E_start = 1'b1; E_flush = 1'b1;
    #1;
    check("idle flush stall", {31'd0, E_md_stall}, 32'd0);
    tick();
    E_start = 1'b0; E_flush = 1'b0;
    stall_seen = 0;
    for (int c = 0; c < 36; c++) begin
      if (E_md_stall || E_md_done) stall_seen++;
      tick();
    end
    check("idle flush not accepted", stall_seen, 32'd0);

    E_funct3 = 3'b100; E_op_a = 32'd9; E_op_b = 32'd0; E_rd = 5'd23; E_start = 1'b1;
    tick();
    E_funct3 = 3'b000; E_op_a = 32'd2; E_op_b = 32'd2;
    got = E_md_done ? 1 : 0;
    check("fast done seen", got, 32'd1);
    tick();
    E_start = 1'b0;
    #1;
    check("start in done ignored", {31'd0, E_md_stall}, 32'd0);
    check("result after fast", E_md_result, 32'hFFFFFFFF);

    // Asynchronous reset between edges while busy.
    E_funct3 = 3'b101; E_op_a = 32'd1000; E_op_b = 32'd3; E_rd = 5'd24; E_start = 1'b1;
    tick();
    E_start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2 rst = 1'b1;
    #1;
    check("async rst result", E_md_result, 32'd0);
    check("async rst rd", {27'd0, E_md_rd}, 32'd0);
    check("async rst stall", {31'd0, E_md_stall}, 32'd0);
    check("async rst done", {31'd0, E_md_done}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (E_md_done || E_md_stall) dones++;
    end
    check("no done after rst", dones, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
